// File: rtl/conv_process_array_pkg.sv
// Shared types and elaboration-time helpers for the convolution process array.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction

  // Wide enough that K_DIM^2 full-scale products can never overflow.
  function automatic int acc_w(input int dw, input int k_dim);
    return 2 * dw + clog2(k_dim * k_dim);
  endfunction

endpackage

// File: rtl/conv_process_array_if.sv
// Start/done handshake plus matrix buses between the controller and the array.
// sat_flag exists only when CONV_SAT_EN is defined.
interface conv_process_array_if #(
  parameter int DW     = 8,
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int OUT_W  = 8
) ();
  localparam int OUT_DIM = conv_pkg::out_dim(IN_DIM, K_DIM);

  logic                               active;
  logic [IN_DIM*IN_DIM*DW-1:0]        a_flat;
  logic [K_DIM*K_DIM*DW-1:0]          b_flat;
  logic                               busy;
  logic                               done;
  logic [OUT_DIM*OUT_DIM*OUT_W-1:0]   c_flat;
`ifdef CONV_SAT_EN
  logic                               sat_flag;

  modport master (output active, a_flat, b_flat, input busy, done, c_flat, sat_flag);
  modport slave  (input active, a_flat, b_flat, output busy, done, c_flat, sat_flag);
`else
  modport master (output active, a_flat, b_flat, input busy, done, c_flat);
  modport slave  (input active, a_flat, b_flat, output busy, done, c_flat);
`endif
endinterface

// File: rtl/conv_process_array_mac.sv
// Single multiply-accumulate unit: DW x DW unsigned product into an ACC_W accumulator.
module conv_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);
  logic [2*DW-1:0] prod;

  assign prod = a * b;

  // Accumulate one product per enabled cycle; clear has priority over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/conv_process_array.sv
// Valid-mode stride-1 2-D convolution using one time-multiplexed MAC.
// Optional macro CONV_SAT_EN: saturate results to 2^OUT_W-1 and report sat_flag.
module conv_process_array
  import conv_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IN_DIM = 4,
  parameter int K_DIM  = 3,
  parameter int OUT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  conv_process_array_if.slave bus
);
  localparam int OUT_DIM = out_dim(IN_DIM, K_DIM);
  localparam int ACC_W   = acc_w(DW, K_DIM);
  localparam int CNT_W   = clog2(IN_DIM + 1);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(K_DIM - 1);
  localparam logic [CNT_W-1:0] LAST_O = CNT_W'(OUT_DIM - 1);

  state_t                           state;
  logic [IN_DIM*IN_DIM*DW-1:0]      a_reg;
  logic [K_DIM*K_DIM*DW-1:0]        b_reg;
  logic [OUT_DIM*OUT_DIM*OUT_W-1:0] c_reg;
  logic [CNT_W-1:0]                 orow, ocol, kr, kc;
  logic                             busy_q, done_q;
  logic [DW-1:0]                    a_op, b_op;
  logic [ACC_W-1:0]                 acc;
  logic [OUT_W-1:0]                 result;
  logic                             mac_en, mac_clr;
  int unsigned                      a_idx, b_idx, c_idx;
`ifdef CONV_SAT_EN
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  logic                             sat_hit;
  logic                             sat_q;
`endif

  assign mac_en  = (state == MAC);
  assign mac_clr = (state == LOAD) || (state == WRITE);

  // Select the current A window element and kernel element for the MAC.
  always_comb begin
    a_idx = (32'(orow) + 32'(kr)) * IN_DIM + 32'(ocol) + 32'(kc);
    b_idx = 32'(kr) * K_DIM + 32'(kc);
    c_idx = 32'(orow) * OUT_DIM + 32'(ocol);
    a_op  = a_reg[a_idx*DW +: DW];
    b_op  = b_reg[b_idx*DW +: DW];
  end

  // Narrow the accumulator to OUT_W: wrap by default, clamp when saturation is built in.
  always_comb begin
    result = OUT_W'(acc);
`ifdef CONV_SAT_EN
    sat_hit = 1'b0;
    if (CMP_W'(acc) > CMP_W'({OUT_W{1'b1}})) begin
      result  = '1;
      sat_hit = 1'b1;
    end
`endif
  end

  conv_mac #(
    .DW   (DW),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr),
    .en (mac_en),
    .a  (a_op),
    .b  (b_op),
    .acc(acc)
  );

  // Control FSM: capture operands, walk kernel then output positions, write results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      c_reg  <= '0;
      orow   <= '0;
      ocol   <= '0;
      kr     <= '0;
      kc     <= '0;
`ifdef CONV_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.active) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          a_reg <= bus.a_flat;
          b_reg <= bus.b_flat;
          orow  <= '0;
          ocol  <= '0;
          kr    <= '0;
          kc    <= '0;
`ifdef CONV_SAT_EN
          sat_q <= 1'b0;
`endif
          state <= MAC;
        end
        MAC: begin
          if (kc == LAST_K) begin
            kc <= '0;
            if (kr == LAST_K) begin
              kr    <= '0;
              state <= WRITE;
            end else begin
              kr <= kr + 1'b1;
            end
          end else begin
            kc <= kc + 1'b1;
          end
        end
        WRITE: begin
          c_reg[c_idx*OUT_W +: OUT_W] <= result;
`ifdef CONV_SAT_EN
          if (sat_hit) sat_q <= 1'b1;
`endif
          if (ocol == LAST_O) begin
            ocol <= '0;
            if (orow == LAST_O) begin
              orow  <= '0;
              state <= DONE;
            end else begin
              orow  <= orow + 1'b1;
              state <= MAC;
            end
          end else begin
            ocol  <= ocol + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.c_flat = c_reg;
`ifdef CONV_SAT_EN
  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_conv_process_array.sv
// Self-checking bench for conv_process_array: three configurations checked
// against a plain-arithmetic convolution model.
module tb_conv_process_array;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  int unsigned a_m[25];
  int unsigned b_m[25];
  int in_d[3] = '{4, 4, 5};
  int k_d[3]  = '{3, 3, 5};
  int w_d[3]  = '{8, 16, 8};

  conv_process_array_if #(.DW(8), .IN_DIM(4), .K_DIM(3), .OUT_W(8))  bus0 ();
  conv_process_array_if #(.DW(8), .IN_DIM(4), .K_DIM(3), .OUT_W(16)) bus1 ();
  conv_process_array_if #(.DW(8), .IN_DIM(5), .K_DIM(5), .OUT_W(8))  bus2 ();

  conv_process_array #(.DW(8), .IN_DIM(4), .K_DIM(3), .OUT_W(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  conv_process_array #(.DW(8), .IN_DIM(4), .K_DIM(3), .OUT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  conv_process_array #(.DW(8), .IN_DIM(5), .K_DIM(5), .OUT_W(8))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int od(input int sel);
    return in_d[sel] - k_d[sel] + 1;
  endfunction

  function automatic int exp_lat(input int sel);
    return 2 + od(sel) * od(sel) * (k_d[sel] * k_d[sel] + 1);
  endfunction

  function automatic int unsigned model_sum(input int sel, input int r, input int c);
    int unsigned s;
    s = 0;
    for (int i = 0; i < k_d[sel]; i++)
      for (int j = 0; j < k_d[sel]; j++)
        s += a_m[(r + i) * in_d[sel] + c + j] * b_m[i * k_d[sel] + j];
    return s;
  endfunction

  function automatic int unsigned model_c(input int sel, input int idx);
    int unsigned s, mx;
    s  = model_sum(sel, idx / od(sel), idx % od(sel));
    mx = (32'd1 << w_d[sel]) - 1;
`ifdef CONV_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  function automatic bit model_sat(input int sel);
    bit any;
    any = 1'b0;
    for (int i = 0; i < od(sel) * od(sel); i++)
      if (model_sum(sel, i / od(sel), i % od(sel)) > (32'd1 << w_d[sel]) - 1) any = 1'b1;
    return any;
  endfunction

  // ---------------- DUT access ----------------
  function automatic logic get_done(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_c(input int sel, input int idx);
    case (sel)
      0:       return 32'(bus0.c_flat[idx*8 +: 8]);
      1:       return 32'(bus1.c_flat[idx*16 +: 16]);
      default: return 32'(bus2.c_flat);
    endcase
  endfunction

`ifdef CONV_SAT_EN
  function automatic logic get_sat(input int sel);
    case (sel)
      0:       return bus0.sat_flag;
      1:       return bus1.sat_flag;
      default: return bus2.sat_flag;
    endcase
  endfunction
`endif

  task automatic set_active(input int sel, input logic v);
    case (sel)
      0:       bus0.active = v;
      1:       bus1.active = v;
      default: bus2.active = v;
    endcase
  endtask

  task automatic load_inputs(input int sel);
    case (sel)
      0: begin
        for (int i = 0; i < 16; i++) bus0.a_flat[i*8 +: 8] = 8'(a_m[i]);
        for (int i = 0; i < 9; i++)  bus0.b_flat[i*8 +: 8] = 8'(b_m[i]);
      end
      1: begin
        for (int i = 0; i < 16; i++) bus1.a_flat[i*8 +: 8] = 8'(a_m[i]);
        for (int i = 0; i < 9; i++)  bus1.b_flat[i*8 +: 8] = 8'(b_m[i]);
      end
      default: begin
        for (int i = 0; i < 25; i++) bus2.a_flat[i*8 +: 8] = 8'(a_m[i]);
        for (int i = 0; i < 25; i++) bus2.b_flat[i*8 +: 8] = 8'(b_m[i]);
      end
    endcase
  endtask

  task automatic rand_data(input int unsigned maxv);
    for (int i = 0; i < 25; i++) begin
      a_m[i] = $urandom_range(0, maxv);
      b_m[i] = $urandom_range(0, maxv);
    end
  endtask

  // Pulse active for one cycle, then count edges until done (lat = -1 on timeout).
  task automatic run(input int sel, output int lat, output int busy_low);
    lat = 0;
    busy_low = 0;
    @(negedge clk); set_active(sel, 1'b1);
    @(posedge clk); #1;
    if (get_busy(sel) !== 1'b1) busy_low++;
    @(negedge clk); set_active(sel, 1'b0);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(sel) === 1'b1) return;
      if (get_busy(sel) !== 1'b1) busy_low++;
    end
    lat = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus0.active = 1'b0; bus1.active = 1'b0; bus2.active = 1'b0;
    bus0.a_flat = '0; bus0.b_flat = '0;
    bus1.a_flat = '0; bus1.b_flat = '0;
    bus2.a_flat = '0; bus2.b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      errors++; $display("FAIL reset_ctl0: busy=%b done=%b, expected 0 0", bus0.busy, bus0.done);
    end
    checks++;
    if (bus0.c_flat !== '0) begin
      errors++; $display("FAIL reset_c0: c_flat=%h, expected 0", bus0.c_flat);
    end
    checks++;
    if (bus1.c_flat !== '0 || bus1.busy !== 1'b0) begin
      errors++; $display("FAIL reset_c1: c_flat=%h busy=%b, expected 0 0", bus1.c_flat, bus1.busy);
    end
    checks++;
    if (bus2.c_flat !== '0 || bus2.done !== 1'b0) begin
      errors++; $display("FAIL reset_c2: c_flat=%h done=%b, expected 0 0", bus2.c_flat, bus2.done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bl;
    int unsigned exp_k[4];
`ifdef CONV_SAT_EN
    exp_k = '{255, 255, 255, 255};
`else
    exp_k = '{92, 137, 16, 61};
`endif
    for (int i = 0; i < 25; i++) begin a_m[i] = 0; b_m[i] = 0; end
    for (int i = 0; i < 16; i++) a_m[i] = i + 1;
    for (int i = 0; i < 9; i++)  b_m[i] = i + 1;
    load_inputs(0);
    run(0, lat, bl);
    checks++;
    if (lat != 42) begin errors++; $display("FAIL basic_latency: got %0d, expected 42", lat); end
    checks++;
    if (bl != 0) begin errors++; $display("FAIL basic_busy: busy low %0d cycles, expected 0", bl); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_c(0, i) !== 32'(exp_k[i])) begin
        errors++; $display("FAIL basic_c[%0d]: got %0d, expected %0d", i, get_c(0, i), exp_k[i]);
      end
    end
`ifdef CONV_SAT_EN
    checks++;
    if (get_sat(0) !== 1'b1) begin errors++; $display("FAIL basic_sat: got %b, expected 1", get_sat(0)); end
`endif
    @(posedge clk); #1;
    checks++;
    if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b, expected 0 0", get_done(0), get_busy(0));
    end
  endtask

  task automatic test_out_w16();
    int lat, bl;
    int unsigned exp_k[4];
    exp_k = '{348, 393, 528, 573};
    load_inputs(1);
    run(1, lat, bl);
    checks++;
    if (lat != 42) begin errors++; $display("FAIL w16_latency: got %0d, expected 42", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_c(1, i) !== 32'(exp_k[i])) begin
        errors++; $display("FAIL w16_c[%0d]: got %0d, expected %0d", i, get_c(1, i), exp_k[i]);
      end
    end
  endtask

  task automatic test_ignore_active();
    int lat, pulses, first;
    rand_data(255);
    load_inputs(0);
    @(negedge clk); set_active(0, 1'b1);
    @(posedge clk); #1;
    lat = 0; pulses = 0; first = -1;
    @(negedge clk); set_active(0, 1'b0);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(0) === 1'b1) begin
        pulses++;
        if (first < 0) first = lat;
      end
      @(negedge clk);
      if (lat == 1)  bus0.a_flat = '0;
      if (lat == 10) set_active(0, 1'b1);
      if (lat == 11) set_active(0, 1'b0);
    end
    checks++;
    if (first != 42) begin errors++; $display("FAIL ignore_latency: got %0d, expected 42", first); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d done pulses, expected 1", pulses); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_c(0, i) !== 32'(model_c(0, i))) begin
        errors++; $display("FAIL ignore_c[%0d]: got %0d, expected %0d", i, get_c(0, i), model_c(0, i));
      end
    end
    load_inputs(0);
  endtask

  task automatic test_reset_mid();
    int lat, bl;
    rand_data(255);
    load_inputs(0);
    @(negedge clk); set_active(0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); set_active(0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.c_flat !== '0) begin
      errors++; $display("FAIL midreset: busy=%b done=%b c_flat=%h, expected 0 0 0", bus0.busy, bus0.done, bus0.c_flat);
    end
    @(negedge clk);
    rst = 1'b1;
    run(0, lat, bl);
    checks++;
    if (lat != 42) begin errors++; $display("FAIL midreset_latency: got %0d, expected 42", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_c(0, i) !== 32'(model_c(0, i))) begin
        errors++; $display("FAIL midreset_c[%0d]: got %0d, expected %0d", i, get_c(0, i), model_c(0, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2, hold_bad, fw_bad;
    int unsigned old_exp[4];
    rand_data(255);
    load_inputs(0);
    t = 0; t1 = -1; t2 = -1; hold_bad = 0; fw_bad = 0;
    @(negedge clk); set_active(0, 1'b1);
    @(posedge clk); #1;
    for (int n = 0; n < 150 && t2 < 0; n++) begin
      @(posedge clk); #1;
      t++;
      if (get_done(0) === 1'b1) begin
        if (t1 < 0) begin
          t1 = t;
          for (int i = 0; i < 4; i++) old_exp[i] = model_c(0, i);
        end else begin
          t2 = t;
        end
      end
      if (t1 >= 0 && t2 < 0 && t <= t1 + 11)
        for (int i = 0; i < 4; i++)
          if (get_c(0, i) !== 32'(old_exp[i])) hold_bad++;
      if (t1 >= 0 && t == t1 + 12) begin
        if (get_c(0, 0) !== 32'(model_c(0, 0))) fw_bad++;
        for (int i = 1; i < 4; i++)
          if (get_c(0, i) !== 32'(old_exp[i])) fw_bad++;
      end
      @(negedge clk);
      if (t == t1) begin
        rand_data(255);
        load_inputs(0);
      end
    end
    set_active(0, 1'b0);
    checks++;
    if (t1 != 42) begin errors++; $display("FAIL b2b_first: got %0d, expected 42", t1); end
    checks++;
    if (t2 - t1 != 43) begin errors++; $display("FAIL b2b_spacing: got %0d, expected 43", t2 - t1); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold: %0d elements changed, expected 0", hold_bad); end
    checks++;
    if (fw_bad != 0) begin errors++; $display("FAIL b2b_first_write: %0d wrong elements, expected 0", fw_bad); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_c(0, i) !== 32'(model_c(0, i))) begin
        errors++; $display("FAIL b2b_c[%0d]: got %0d, expected %0d", i, get_c(0, i), model_c(0, i));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (get_busy(0) !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b, expected 0", get_busy(0)); end
  endtask

  task automatic test_single_output();
    int lat, bl;
    for (int i = 0; i < 25; i++) begin a_m[i] = 1; b_m[i] = 1; end
    load_inputs(2);
    run(2, lat, bl);
    checks++;
    if (lat != 28) begin errors++; $display("FAIL single_latency: got %0d, expected 28", lat); end
    checks++;
    if (get_c(2, 0) !== 32'd25) begin errors++; $display("FAIL single_c: got %0d, expected 25", get_c(2, 0)); end
    rand_data(255);
    load_inputs(2);
    run(2, lat, bl);
    checks++;
    if (lat != 28 || bl != 0) begin
      errors++; $display("FAIL single_rand_timing: latency %0d busy-low %0d, expected 28 0", lat, bl);
    end
    checks++;
    if (get_c(2, 0) !== 32'(model_c(2, 0))) begin
      errors++; $display("FAIL single_rand_c: got %0d, expected %0d", get_c(2, 0), model_c(2, 0));
    end
  endtask

  task automatic test_random();
    int lat, bl;
    for (int it = 0; it < 5; it++) begin
      for (int sel = 0; sel < 2; sel++) begin
        if (it == 4) begin
          for (int i = 0; i < 25; i++) begin a_m[i] = 255; b_m[i] = 255; end
        end else begin
          rand_data((it % 2 == 0) ? 255 : 3);
        end
        load_inputs(sel);
        run(sel, lat, bl);
        checks++;
        if (lat != exp_lat(sel)) begin
          errors++; $display("FAIL rand_latency it%0d sel%0d: got %0d, expected %0d", it, sel, lat, exp_lat(sel));
        end
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (get_c(sel, i) !== 32'(model_c(sel, i))) begin
            errors++; $display("FAIL rand_c it%0d sel%0d [%0d]: got %0d, expected %0d", it, sel, i, get_c(sel, i), model_c(sel, i));
          end
        end
`ifdef CONV_SAT_EN
        checks++;
        if (get_sat(sel) !== model_sat(sel)) begin
          errors++; $display("FAIL rand_sat it%0d sel%0d: got %b, expected %b", it, sel, get_sat(sel), model_sat(sel));
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_w16();
    test_ignore_active();
    test_reset_mid();
    test_back_to_back();
    test_single_output();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
